// File: rtl/classifier_sequencer.sv
// classifier_sequencer
// Sequences the linear-SVM classifier: forwards model-upload bytes while
// tracking upload progress, admits whole feature frames only when a valid
// model is resident and the classifier is idle, waits out the decision
// latency, and smooths the sampled decisions with a K-of-N vote.
// Stalled or empty uploads are aborted by pulsing the classifier reset.

module classifier_sequencer #(
    parameter int NUM_FEATURES_IN = 16,
    parameter int DECISION_SLACK  = 10,
    parameter int TIMEOUT_CYCLES  = 1000000,
    parameter int N_VOTE          = 5,
    parameter int K_VOTE          = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [7:0]  ble_data_in,
    input  logic        ble_valid_in,
    output logic [7:0]  ble_data_out,
    output logic        ble_valid_out,
    input  logic [15:0] feature_data_in,
    input  logic        feature_valid_in,
    input  logic        feature_last_in,
    output logic [15:0] feature_data_out,
    output logic        feature_valid_out,
    output logic        feature_last_out,
    output logic        predict_enable_out,
    input  logic        classifier_detected_in,
    output logic        classifier_rst_out,
    output logic        model_loaded_out,
    output logic        load_error_out,
    output logic        decision_valid_out,
    output logic        detected_out,
    output logic [15:0] dropped_frames_out
);

    // Sequencer states
    localparam logic [2:0] ST_EMPTY   = 3'd0;
    localparam logic [2:0] ST_LOADING = 3'd1;
    localparam logic [2:0] ST_READY   = 3'd2;
    localparam logic [2:0] ST_FORWARD = 3'd3;
    localparam logic [2:0] ST_WAIT    = 3'd4;

    // Upload is: 1 header byte, 2 bytes per stored feature per support vector,
    // 4 trailing bytes. The counter must cover the largest model (N = 255).
    localparam int BYTES_PER_SV = 2 * (NUM_FEATURES_IN - 1);
    localparam int MAX_BYTES    = 5 + 255 * BYTES_PER_SV;
    localparam int CNT_W        = $clog2(MAX_BYTES + 1);
    localparam int TO_W         = $clog2(TIMEOUT_CYCLES + 1);
    localparam int WAIT_W       = $clog2(255 + DECISION_SLACK + 1);
    localparam int POP_W        = $clog2(N_VOTE + 1);

    // Number of ones in the vote history
    function automatic logic [POP_W-1:0] popcount(input logic [N_VOTE-1:0] v);
        logic [POP_W-1:0] cnt;
        cnt = {POP_W{1'b0}};
        for (int i = 0; i < N_VOTE; i++) begin
            cnt = cnt + POP_W'(v[i]);
        end
        return cnt;
    endfunction

    logic [2:0]        state_r;
    logic [2:0]        next_state_s;
    logic [7:0]        num_supports_r;
    logic [CNT_W-1:0]  byte_cnt_r;
    logic [CNT_W-1:0]  total_r;
    logic [CNT_W-1:0]  total_s;
    logic [TO_W-1:0]   idle_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [N_VOTE-1:0] history_r;
    logic [N_VOTE-1:0] hist_next_s;
    logic [N_VOTE:0]   hist_shift_s;
    logic [POP_W-1:0]  pop_s;
    logic              frame_open_r;
    logic              drop_r;

    logic upload_start_s;
    logic first_beat_s;
    logic admit_s;
    logic cont_fwd_s;
    logic fwd_s;
    logic drop_first_s;
    logic frame_done_s;
    logic decide_s;
    logic zero_abort_s;
    logic load_byte_s;
    logic load_done_s;
    logic timeout_s;

    // Decode this cycle's events and the next sequencer state
    always_comb begin
        upload_start_s = 1'b0;
        case (state_r)
            ST_EMPTY, ST_READY, ST_FORWARD, ST_WAIT: upload_start_s = ble_valid_in;
            default:                                 upload_start_s = 1'b0;
        endcase

        // An upload byte always beats a frame arriving in the same cycle
        first_beat_s = feature_valid_in & ~frame_open_r;
        admit_s      = first_beat_s & (state_r == ST_READY) & ~ble_valid_in;
        cont_fwd_s   = feature_valid_in & frame_open_r & ~drop_r &
                       (state_r == ST_FORWARD) & ~ble_valid_in;
        fwd_s        = admit_s | cont_fwd_s;
        drop_first_s = first_beat_s & ~admit_s;
        frame_done_s = fwd_s & feature_last_in;

        decide_s     = (state_r == ST_WAIT) & ~ble_valid_in &
                       (wait_cnt_r <= WAIT_W'(1));

        // An empty model is rejected one cycle after its header byte
        zero_abort_s = (state_r == ST_LOADING) & (num_supports_r == 8'd0);
        load_byte_s  = (state_r == ST_LOADING) & ~zero_abort_s & ble_valid_in;
        load_done_s  = load_byte_s & ((byte_cnt_r + CNT_W'(1)) == total_r);
        // A byte on the final allowed idle cycle still counts
        timeout_s    = (state_r == ST_LOADING) & ~zero_abort_s & ~ble_valid_in &
                       (idle_r == TO_W'(TIMEOUT_CYCLES));

        total_s = CNT_W'(ble_data_in) * CNT_W'(BYTES_PER_SV) + CNT_W'(5);

        hist_shift_s = {history_r, classifier_detected_in};
        hist_next_s  = hist_shift_s[N_VOTE-1:0];
        pop_s        = popcount(hist_next_s);

        next_state_s = state_r;
        if (upload_start_s) begin
            next_state_s = ST_LOADING;
        end else begin
            case (state_r)
                ST_EMPTY: next_state_s = ST_EMPTY;
                ST_LOADING: begin
                    if (zero_abort_s || timeout_s) begin
                        next_state_s = ST_EMPTY;
                    end else if (load_done_s) begin
                        next_state_s = ST_READY;
                    end else begin
                        next_state_s = ST_LOADING;
                    end
                end
                ST_READY: begin
                    if (admit_s) begin
                        next_state_s = feature_last_in ? ST_WAIT : ST_FORWARD;
                    end else begin
                        next_state_s = ST_READY;
                    end
                end
                ST_FORWARD: begin
                    if (frame_done_s) begin
                        next_state_s = ST_WAIT;
                    end else begin
                        next_state_s = ST_FORWARD;
                    end
                end
                ST_WAIT: begin
                    if (decide_s) begin
                        next_state_s = ST_READY;
                    end else begin
                        next_state_s = ST_WAIT;
                    end
                end
                default: next_state_s = ST_EMPTY;
            endcase
        end
    end

    // Sequencer state register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Upload byte counting and idle-gap tracking
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            num_supports_r <= 8'd0;
            total_r        <= {CNT_W{1'b0}};
            byte_cnt_r     <= {CNT_W{1'b0}};
            idle_r         <= {TO_W{1'b0}};
        end else if (upload_start_s) begin
            num_supports_r <= ble_data_in;
            total_r        <= total_s;
            byte_cnt_r     <= CNT_W'(1);
            idle_r         <= {TO_W{1'b0}};
        end else if (state_r == ST_LOADING) begin
            if (ble_valid_in) begin
                byte_cnt_r <= byte_cnt_r + CNT_W'(1);
                idle_r     <= {TO_W{1'b0}};
            end else begin
                idle_r     <= idle_r + TO_W'(1);
            end
        end else begin
            idle_r <= {TO_W{1'b0}};
        end
    end

    // Model status flags and the classifier abort pulse
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            model_loaded_out   <= 1'b0;
            load_error_out     <= 1'b0;
            classifier_rst_out <= 1'b0;
        end else begin
            classifier_rst_out <= zero_abort_s | timeout_s;
            if (upload_start_s) begin
                model_loaded_out <= 1'b0;
                load_error_out   <= 1'b0;
            end else if (zero_abort_s || timeout_s) begin
                load_error_out   <= 1'b1;
            end else if (load_done_s) begin
                model_loaded_out <= 1'b1;
            end
        end
    end

    // Registered forwarding of upload bytes and admitted feature beats
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ble_data_out       <= 8'd0;
            ble_valid_out      <= 1'b0;
            feature_data_out   <= 16'd0;
            feature_valid_out  <= 1'b0;
            feature_last_out   <= 1'b0;
            predict_enable_out <= 1'b0;
        end else begin
            ble_data_out       <= ble_data_in;
            ble_valid_out      <= ble_valid_in;
            feature_valid_out  <= fwd_s;
            feature_last_out   <= fwd_s & feature_last_in;
            predict_enable_out <= admit_s;
            if (fwd_s) begin
                feature_data_out <= feature_data_in;
            end
        end
    end

    // Frame boundary tracking and rejected-frame counting
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            frame_open_r       <= 1'b0;
            drop_r             <= 1'b0;
            dropped_frames_out <= 16'd0;
        end else begin
            if (feature_valid_in) begin
                frame_open_r <= ~feature_last_in;
                if (first_beat_s) begin
                    drop_r <= ~admit_s;
                end else begin
                    // An upload starting mid-frame discards the remainder
                    drop_r <= drop_r | upload_start_s;
                end
            end else if (upload_start_s && (state_r == ST_FORWARD)) begin
                drop_r <= 1'b1;
            end
            if (drop_first_s && (dropped_frames_out != 16'hFFFF)) begin
                dropped_frames_out <= dropped_frames_out + 16'd1;
            end
        end
    end

    // Decision timer, vote history and debounced detection
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wait_cnt_r         <= {WAIT_W{1'b0}};
            history_r          <= {N_VOTE{1'b0}};
            decision_valid_out <= 1'b0;
            detected_out       <= 1'b0;
        end else begin
            decision_valid_out <= decide_s;
            if (frame_done_s) begin
                wait_cnt_r <= WAIT_W'(num_supports_r) + WAIT_W'(DECISION_SLACK);
            end else if ((state_r == ST_WAIT) && !decide_s) begin
                wait_cnt_r <= wait_cnt_r - WAIT_W'(1);
            end
            if (load_done_s) begin
                history_r    <= {N_VOTE{1'b0}};
                detected_out <= 1'b0;
            end else if (decide_s) begin
                history_r    <= hist_next_s;
                detected_out <= (pop_s >= POP_W'(K_VOTE));
            end
        end
    end

endmodule

// File: doc/classifier_sequencer.md
Name: classifier_sequencer

Overview:
- Sits between the BLE/UART byte stream, the feature extractor and the linear-SVM classifier; owns all classifier sequencing.
- Tracks model uploads byte-by-byte and forwards bytes unchanged. Blocks prediction while no valid model is loaded or an upload is in flight.
- Admits whole feature frames only when the classifier is idle, times the decision, and applies K-of-N vote smoothing to produce a debounced detection.
- Aborts stalled or invalid uploads by pulsing the classifier's reset.

Parameters:
- NUM_FEATURES_IN, 16, features per frame; classifier stores features 1..NUM_FEATURES_IN-1.
- DECISION_SLACK, 10, cycles added to num_supports to form the decision wait after the last forwarded beat.
- TIMEOUT_CYCLES, 1000000, maximum idle gap between upload bytes.
- N_VOTE, 5, vote history depth (1..16).
- K_VOTE, 3, votes required to assert detected_out (1..N_VOTE).

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous, active-high reset
- ble_data_in  in  8  upload byte from UART
- ble_valid_in  in  1  byte strobe
- ble_data_out  out  8  byte to classifier (registered copy)
- ble_valid_out  out  1  strobe to classifier
- feature_data_in  in  16  signed feature beat
- feature_valid_in  in  1  beat valid
- feature_last_in  in  1  final beat of frame
- feature_data_out  out  16  registered beat to classifier
- feature_valid_out  out  1
- feature_last_out  out  1
- predict_enable_out  out  1  classifier predict enable
- classifier_detected_in  in  1  classifier detected_out
- classifier_rst_out  out  1  one-cycle classifier reset pulse
- model_loaded_out  out  1  a complete valid model is resident
- load_error_out  out  1  sticky; set on timeout or num_supports==0; cleared at next upload start
- decision_valid_out  out  1  one-cycle pulse per sampled decision
- detected_out  out  1  vote result
- dropped_frames_out  out  16  saturating count of rejected frames

Behaviour:
- Reset: asynchronous. All outputs 0; FSM in EMPTY; vote history cleared.
- Registered forwarding:
  - All *_out data and strobes are registered copies of the inputs, with 1-cycle latency.
  - BLE bytes are always forwarded, whatever the state.
  - Feature beats are forwarded only for admitted frames. predict_enable_out is high on the cycle the first admitted beat appears on feature_*_out and low otherwise.
- Upload tracking:
  - A byte arriving in EMPTY, READY, FORWARD or WAIT starts an upload: latch num_supports N = byte, clear load_error_out, clear model_loaded_out, go to LOADING.
  - If the upload starts in FORWARD, the rest of that frame is discarded. If it starts in WAIT, no decision is emitted.
  - Expected total upload length = 1 + 2*N*(NUM_FEATURES_IN-1) + 4 bytes. The byte counter must be wide enough for N=255.
  - LOADING: count bytes. When the final byte is counted, set model_loaded_out, clear the vote history and detected_out, and go to READY.
  - LOADING with an idle gap exceeding TIMEOUT_CYCLES: pulse classifier_rst_out, set load_error_out, go to EMPTY.
  - N==0: on the cycle after the first byte, pulse classifier_rst_out, set load_error_out, go to EMPTY.
- Frame admission:
  - The first beat of a frame (feature_valid_in with no frame open) is admitted only in READY; the FSM then goes to FORWARD.
  - Otherwise the whole frame, through its feature_last_in beat, is swallowed and dropped_frames_out increments once. The counter saturates at 65535.
  - A single-beat frame (valid and last together) is legal.
- FORWARD: pass beats through. On the last beat, load the wait counter with N + DECISION_SLACK and go to WAIT.
- WAIT: decrement the counter. At zero, sample classifier_detected_in, shift it into the N_VOTE-deep history, and pulse decision_valid_out. On the same cycle, detected_out = (popcount(history) >= K_VOTE), and the FSM returns to READY.
- Simultaneous events:
  - If an upload byte and a first feature beat arrive in the same cycle in READY, the upload wins and the frame is dropped.
  - If an upload byte arrives on the last LOADING timeout cycle, the byte counts and no timeout is taken.

Test Plan:
- Upload N=2 with 2*2*15+5=65 bytes, then 16-beat frame with classifier_detected_in=1 → model_loaded_out rises after the 65th byte; predict_enable_out high one cycle; decision_valid_out pulses 2+10 cycles after the forwarded last beat; detected_out stays 0 (1 of 3 votes).
- Three consecutive frames, detected in=1,1,1 → detected_out rises on the 3rd decision. Then 0,0,0 → detected_out falls on the 3rd zero (history reaches 2 of 5 ones).
- Frames sent before any upload, and during LOADING → not forwarded; dropped_frames_out counts 1 per frame; no decision_valid_out.
- Upload stalls after 10 bytes for TIMEOUT_CYCLES+1 → classifier_rst_out single pulse; load_error_out=1; EMPTY. The next upload clears load_error_out.
- First byte 0x00 → classifier_rst_out pulse, load_error_out=1, model_loaded_out=0.
- Upload byte during WAIT → no decision pulse; LOADING entered. Separately, assert rst_in mid-FORWARD → all outputs 0 immediately.
